alu_share_arbiter: RTL and testbench
====================================

Name: alu_share_arbiter

Overview:
- Shares one combinational ALU instance between NREQ requesters, for example the execute stage, the branch-target adder path and a CSR read-modify-write sequencer.
- Round-robin arbitration, valid/ready handshake on both request and response sides.
- One-entry registered result buffer, so the ALU output is never a combinational path to any requester.
- Sits in the execute cluster between the requesters and the single ALU.

Parameters:
- NREQ, 2, number of requesters (2..8).
- XLEN, 32, operand/result width.
- IDW, 3, requester-id width; must satisfy 2**IDW >= NREQ.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester accept; at most one bit high in any cycle.
- req_op  in  4*NREQ  ALU op of requester i in bits [4i+3:4i].
- req_a  in  XLEN*NREQ  operand A of requester i, packed the same way.
- req_b  in  XLEN*NREQ  operand B of requester i, packed the same way.
- rsp_valid  out  1  result buffer holds a valid result.
- rsp_id  out  IDW  index of the requester that owns the buffered result.
- rsp_result  out  XLEN  buffered ALU result.
- rsp_ready  in  NREQ  per-requester response accept; only bit rsp_id is sampled.
- busy  out  1  result buffer occupied (equals rsp_valid; for stall logic).

Behaviour:
- Reset (async, while rst_n=0):
  - rsp_valid=0, rsp_id=0, rsp_result=0, rr_ptr=0, buffer state=EMPTY.
  - req_ready=0 while in reset.
- State machine (2 states, result buffer):
  - EMPTY -> FULL on grant.
  - FULL -> EMPTY on drain with no new grant.
  - FULL -> FULL on drain with a simultaneous grant (back-to-back).
  - FULL holds while rsp_ready[rsp_id]=0.
- can_accept = (state==EMPTY) or (state==FULL and rsp_ready[rsp_id]=1).
- Arbitration:
  - When can_accept, grant the first i with req_valid[i]=1, searching from rr_ptr upward modulo NREQ.
  - req_ready[i]=1 only for the granted i. No grant means req_ready is all zeros.
  - req_ready depends combinationally on req_valid. Requesters must not make req_valid depend on req_ready.
- Transfer occurs when req_valid[i] & req_ready[i]. On that edge:
  - rsp_result <= ALU(req_op[i], req_a[i], req_b[i]).
  - rsp_id <= i, rsp_valid <= 1.
  - rr_ptr <= (i+1) mod NREQ.
- Latency: result visible on rsp_* exactly 1 cycle after the accepting edge.
- Throughput: 1 op/cycle when the owner holds rsp_ready=1 continuously.
- Drain: rsp_valid & rsp_ready[rsp_id] at an edge with no new grant -> rsp_valid <= 0. rsp_result and rsp_id hold their last values.
- Stability: while FULL and not drained, rsp_result and rsp_id are stable. rr_ptr is unchanged when no grant occurs.
- ALU op encoding (4 bits): ADD 0, SUB 1, AND 2, OR 3, PASSB 4, SLT 5, XOR 6, SRL 7, SLL 8, SRA 9, SLTU A. Codes B..F produce result 0.
  - Shifts use b[4:0].
  - SLT and SLTU zero-extend the 1-bit comparison result.
  - Arithmetic wraps modulo 2**XLEN.
- Requester contract: a requester with req_valid=1 and req_ready=0 must hold op, a and b stable until accepted. The arbiter does not check this.
- Fairness: with all requesters valid, grants rotate 0,1,..,NREQ-1,0.
- Reset mid-operation: the buffered result is discarded and no response is issued after reset.

Decomposition:
- Shared package alu_pkg:
  - ALU op localparams (ALU_ADD..ALU_SLTU) with the encoding above.
  - XLEN default.
- Sub-module: alu_core, the combinational ALU (op, a, b -> result), instantiated once behind the operand mux.
- A round-robin priority function is local to alu_share_arbiter.

Test Plan:
- Reset: rst_n=0 mid-burst with rsp_valid=1 -> rsp_valid=0, rsp_result=0, rr_ptr=0 immediately (async); no stale response after release.
- Single op: req0 ADD a=0xFFFFFFFF b=2, rsp_ready=1 -> next cycle rsp_valid=1, rsp_id=0, result 0x00000001; then rsp_valid=0.
- Round robin: NREQ=3, all valid, rsp_ready all 1 -> grant order 0,1,2,0,1,2; one result per cycle.
  - Check SRA a=0x80000000 b=4 -> 0xF8000000.
  - Check SLTU 1 vs 0xFFFFFFFF -> 1.
- Backpressure: FULL with rsp_id=1, rsp_ready[1]=0 for 4 cycles while req0 is valid:
  - req_ready all 0 during the stall; rsp_result stable.
  - Raise rsp_ready[1] -> req0 granted the same cycle; its result appears the next cycle.
- Wrong-owner ready: rsp_id=2, only rsp_ready[0]=1 -> no drain, rsp_valid stays 1, no new grant.
- Illegal op: op=0xC a=5 b=7 -> result 0. SLL b=0x25 -> shift by 5.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU opcode encoding, default datapath width and result-buffer state type.
package alu_pkg;

    localparam int XLEN_DEFAULT = 32;

    localparam logic [3:0] ALU_ADD   = 4'h0;
    localparam logic [3:0] ALU_SUB   = 4'h1;
    localparam logic [3:0] ALU_AND   = 4'h2;
    localparam logic [3:0] ALU_OR    = 4'h3;
    localparam logic [3:0] ALU_PASSB = 4'h4;
    localparam logic [3:0] ALU_SLT   = 4'h5;
    localparam logic [3:0] ALU_XOR   = 4'h6;
    localparam logic [3:0] ALU_SRL   = 4'h7;
    localparam logic [3:0] ALU_SLL   = 4'h8;
    localparam logic [3:0] ALU_SRA   = 4'h9;
    localparam logic [3:0] ALU_SLTU  = 4'hA;

    typedef enum logic {BUF_EMPTY = 1'b0, BUF_FULL = 1'b1} buf_state_e;

endpackage

// File: rtl/alu_core.sv
// alu_core: combinational ALU.
//   op     in  4     operation code (alu_pkg encoding; unused codes give 0)
//   a, b   in  XLEN  operands; shifts use b[4:0]
//   result out XLEN  operation result, wrapping modulo 2**XLEN
module alu_core
    import alu_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic [3:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] result
);

    logic [4:0] sh;

    assign sh = b[4:0];

    always_comb begin
        result = '0;
        case (op)
            ALU_ADD:   result = a + b;
            ALU_SUB:   result = a - b;
            ALU_AND:   result = a & b;
            ALU_OR:    result = a | b;
            ALU_PASSB: result = b;
            ALU_SLT:   result = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
            ALU_XOR:   result = a ^ b;
            ALU_SRL:   result = a >> sh;
            ALU_SLL:   result = a << sh;
            ALU_SRA:   result = $signed(a) >>> sh;
            ALU_SLTU:  result = {{(XLEN-1){1'b0}}, a < b};
            default:   result = '0;
        endcase
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin sharing of one ALU among NREQ requesters with a one-entry result buffer.
//   clk, rst_n          clock, asynchronous active-low reset
//   req_valid/req_ready per-requester handshake; req_ready is one-hot or zero
//   req_op/req_a/req_b  packed per-requester op and operands
//   rsp_valid/rsp_id/rsp_result  buffered result and its owner
//   rsp_ready           per-requester response accept; only bit rsp_id matters
//   busy                result buffer occupied
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int XLEN = XLEN_DEFAULT,
    parameter int IDW  = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [4*NREQ-1:0]    req_op,
    input  logic [XLEN*NREQ-1:0] req_a,
    input  logic [XLEN*NREQ-1:0] req_b,
    output logic                 rsp_valid,
    output logic [IDW-1:0]       rsp_id,
    output logic [XLEN-1:0]      rsp_result,
    input  logic [NREQ-1:0]      rsp_ready,
    output logic                 busy
);

    buf_state_e      state_q, state_d;
    logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]  rsp_id_q, rsp_id_d;
    logic [XLEN-1:0] rsp_result_q, rsp_result_d;
    logic [IDW:0]    pick;
    logic [IDW-1:0]  gnt_id;
    logic            owner_ready, drain, can_accept, grant;
    logic [3:0]      sel_op;
    logic [XLEN-1:0] sel_a, sel_b, alu_res;

    // Returns {found, index} of the first valid requester at or after ptr, modulo NREQ.
    // Scanning from the far end lets the closest candidate overwrite the others.
    function automatic logic [IDW:0] rr_pick(input logic [NREQ-1:0] v, input logic [IDW-1:0] ptr);
        logic [IDW:0] r;
        int j;
        r = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            j = int'(ptr) + k;
            if (j >= NREQ) j -= NREQ;
            if (v[j]) r = {1'b1, IDW'(j)};
        end
        return r;
    endfunction

    always_comb begin
        owner_ready = 1'b0;
        for (int i = 0; i < NREQ; i++)
            if (rsp_id_q == IDW'(i)) owner_ready = rsp_ready[i];
        drain      = (state_q == BUF_FULL) && owner_ready;
        // rst_n gating keeps req_ready low for the whole reset interval.
        can_accept = rst_n && ((state_q == BUF_EMPTY) || drain);
        pick       = rr_pick(req_valid, rr_ptr_q);
        grant      = can_accept && pick[IDW];
        gnt_id     = pick[IDW-1:0];
        req_ready  = '0;
        sel_op     = '0;
        sel_a      = '0;
        sel_b      = '0;
        for (int i = 0; i < NREQ; i++)
            if (grant && gnt_id == IDW'(i)) begin
                req_ready[i] = 1'b1;
                sel_op       = req_op[4*i +: 4];
                sel_a        = req_a[XLEN*i +: XLEN];
                sel_b        = req_b[XLEN*i +: XLEN];
            end
    end

    alu_core #(.XLEN(XLEN)) u_alu (
        .op     (sel_op),
        .a      (sel_a),
        .b      (sel_b),
        .result (alu_res)
    );

    always_comb begin
        state_d      = grant ? BUF_FULL : (drain ? BUF_EMPTY : state_q);
        rr_ptr_d     = grant ? ((int'(gnt_id) == NREQ - 1) ? '0 : gnt_id + 1'b1) : rr_ptr_q;
        rsp_id_d     = grant ? gnt_id : rsp_id_q;
        rsp_result_d = grant ? alu_res : rsp_result_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= BUF_EMPTY;
            rr_ptr_q     <= '0;
            rsp_id_q     <= '0;
            rsp_result_q <= '0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
        end
    end

    assign rsp_valid  = (state_q == BUF_FULL);
    assign busy       = rsp_valid;
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: vector table, directed corner sequences and random traffic against a reference model.
module tb_alu_share_arbiter;

    localparam int NREQ = 3;
    localparam int XLEN = 32;
    localparam int IDW  = 3;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NREQ-1:0]      req_valid, req_ready, rsp_ready;
    logic [4*NREQ-1:0]    req_op;
    logic [XLEN*NREQ-1:0] req_a, req_b;
    logic                 rsp_valid, busy;
    logic [IDW-1:0]       rsp_id;
    logic [XLEN-1:0]      rsp_result;

    int errors = 0;
    int checks = 0;

    logic        m_valid;
    int          m_id, m_ptr, last_g;
    logic [31:0] m_result;
    logic [2:0]  last_ready;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vt[16];

    alu_share_arbiter #(.NREQ(NREQ), .XLEN(XLEN), .IDW(IDW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .rsp_valid  (rsp_valid),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_ready  (rsp_ready),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int unsigned sh;
        sh = int'(b % 32);
        case (op)
            4'h0: return 32'(a + b);
            4'h1: return 32'(a - b);
            4'h2: return a & b;
            4'h3: return a | b;
            4'h4: return b;
            4'h5: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            4'h6: return a ^ b;
            4'h7: return a >> sh;
            4'h8: return a << sh;
            4'h9: return (a >> sh) | (a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'd0);
            4'hA: return (a < b) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    function automatic int exp_grant();
        if (!rst_n) return -1;
        if (m_valid && !rsp_ready[m_id]) return -1;
        for (int k = 0; k < NREQ; k++)
            if (req_valid[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
        return -1;
    endfunction

    task automatic model_reset();
        m_valid  = 1'b0;
        m_id     = 0;
        m_ptr    = 0;
        m_result = '0;
    endtask

    task automatic set_req(input int i, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        req_op[4*i +: 4]   = op;
        req_a[32*i +: 32]  = a;
        req_b[32*i +: 32]  = b;
    endtask

    // Called at a falling edge with inputs already driven; returns at the next falling edge.
    task automatic cycle();
        int g;
        #1;
        g = exp_grant();
        chk("req_ready", 32'(req_ready), (g >= 0) ? 32'(1 << g) : 32'd0);
        chk("rsp_valid", 32'(rsp_valid), 32'(m_valid));
        chk("busy", 32'(busy), 32'(m_valid));
        chk("rsp_id", 32'(rsp_id), 32'(m_id));
        chk("rsp_result", rsp_result, m_result);
        last_g     = g;
        last_ready = req_ready;
        @(posedge clk);
        if (g >= 0) begin
            m_result = ref_alu(req_op[4*g +: 4], req_a[32*g +: 32], req_b[32*g +: 32]);
            m_id     = g;
            m_valid  = 1'b1;
            m_ptr    = (g + 1) % NREQ;
        end else if (m_valid && rsp_ready[m_id]) begin
            m_valid = 1'b0;
        end
        @(negedge clk);
    endtask

    function automatic logic [31:0] pick_val();
        case ($urandom_range(0, 3))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    logic [31:0] exp_rr[3];
    logic [31:0] saved;

    initial begin
        vt[0]  = '{4'h0, 32'hFFFF_FFFF, 32'h2,         32'h0000_0001};
        vt[1]  = '{4'h1, 32'h0,         32'h1,         32'hFFFF_FFFF};
        vt[2]  = '{4'h2, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000};
        vt[3]  = '{4'h3, 32'hF0F0_F0F0, 32'h0F0F_0000, 32'hFFFF_F0F0};
        vt[4]  = '{4'h4, 32'h1234_5678, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
        vt[5]  = '{4'h5, 32'h8000_0000, 32'h1,         32'h1};
        vt[6]  = '{4'h5, 32'h1,         32'h8000_0000, 32'h0};
        vt[7]  = '{4'h6, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F};
        vt[8]  = '{4'h7, 32'h8000_0000, 32'h1F,        32'h1};
        vt[9]  = '{4'h8, 32'h1,         32'h25,        32'h20};
        vt[10] = '{4'h9, 32'h8000_0000, 32'h4,         32'hF800_0000};
        vt[11] = '{4'hA, 32'h1,         32'hFFFF_FFFF, 32'h1};
        vt[12] = '{4'hA, 32'hFFFF_FFFF, 32'h1,         32'h0};
        vt[13] = '{4'hC, 32'h5,         32'h7,         32'h0};
        vt[14] = '{4'hF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0};
        vt[15] = '{4'h9, 32'h7FFF_FFFF, 32'h21,        32'h3FFF_FFFF};
        exp_rr = '{32'hF800_0000, 32'h1, 32'h7};

        rst_n     = 1'b0;
        req_valid = '1;
        rsp_ready = '1;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
        model_reset();
        #3;
        chk("reset_req_ready", 32'(req_ready), 32'd0);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_rsp_result", rsp_result, 32'd0);
        @(negedge clk);
        cycle();
        rst_n     = 1'b1;
        req_valid = '0;
        cycle();

        foreach (vt[n]) begin
            req_valid = 3'b001;
            rsp_ready = '1;
            set_req(0, vt[n].op, vt[n].a, vt[n].b);
            cycle();
            chk("vec_grant", 32'(last_ready), 32'd1);
            chk("vec_result", rsp_result, vt[n].exp);
            chk("vec_valid", 32'(rsp_valid), 32'd1);
            req_valid = '0;
            cycle();
            chk("vec_drain", 32'(rsp_valid), 32'd0);
        end

        set_req(0, 4'h9, 32'h8000_0000, 32'h4);
        set_req(1, 4'hA, 32'h1, 32'hFFFF_FFFF);
        set_req(2, 4'h0, 32'h3, 32'h4);
        req_valid = '1;
        cycle();
        cycle();
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(rsp_valid), 32'd0);
        chk("async_rst_result", rsp_result, 32'd0);
        chk("async_rst_id", 32'(rsp_id), 32'd0);
        chk("async_rst_ready", 32'(req_ready), 32'd0);
        model_reset();
        @(negedge clk);
        cycle();
        rst_n     = 1'b1;
        req_valid = '0;
        cycle();
        cycle();

        req_valid = '1;
        for (int k = 0; k < 6; k++) begin
            cycle();
            chk("rr_grant", 32'(last_ready), 32'(1 << (k % 3)));
            chk("rr_id", 32'(rsp_id), 32'(k % 3));
            chk("rr_result", rsp_result, exp_rr[k % 3]);
        end

        req_valid = 3'b010;
        cycle();
        chk("bp_setup_id", 32'(rsp_id), 32'd1);
        saved     = rsp_result;
        req_valid = 3'b001;
        rsp_ready = 3'b101;
        for (int k = 0; k < 4; k++) begin
            cycle();
            chk("bp_ready", 32'(last_ready), 32'd0);
            chk("bp_result", rsp_result, saved);
            chk("bp_valid", 32'(rsp_valid), 32'd1);
        end
        rsp_ready = '1;
        cycle();
        chk("bp_release_grant", 32'(last_ready), 32'd1);
        chk("bp_release_id", 32'(rsp_id), 32'd0);
        chk("bp_release_result", rsp_result, 32'hF800_0000);

        req_valid = 3'b100;
        cycle();
        chk("wo_setup_id", 32'(rsp_id), 32'd2);
        req_valid = 3'b011;
        rsp_ready = 3'b001;
        for (int k = 0; k < 2; k++) begin
            cycle();
            chk("wo_ready", 32'(last_ready), 32'd0);
            chk("wo_valid", 32'(rsp_valid), 32'd1);
            chk("wo_id", 32'(rsp_id), 32'd2);
        end
        rsp_ready = '1;
        cycle();
        chk("wo_release_grant", 32'(last_ready), 32'd1);
        req_valid = '0;
        cycle();
        chk("wo_drain", 32'(rsp_valid), 32'd0);

        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!(req_valid[i] && last_g != i)) begin
                    req_valid[i] = ($urandom_range(0, 3) != 0);
                    set_req(i, 4'($urandom_range(0, 15)), pick_val(), pick_val());
                end
            end
            rsp_ready = 3'($urandom);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
